// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
// The overflow signal exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_if #(
  parameter int NUM_BITS = 8
);
  logic                start;
  logic [NUM_BITS-1:0] minuend;
  logic [NUM_BITS-1:0] subtrahend;
  logic                busy;
  logic                done;
  logic [NUM_BITS-1:0] difference;
  logic                borrow_out;
`ifdef SERIAL_SUB_OVF_EN
  logic                overflow;
`endif

  modport master (
    output start, minuend, subtrahend,
`ifdef SERIAL_SUB_OVF_EN
    input  overflow,
`endif
    input  busy, done, difference, borrow_out
  );

  modport slave (
    input  start, minuend, subtrahend,
`ifdef SERIAL_SUB_OVF_EN
    output overflow,
`endif
    output busy, done, difference, borrow_out
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial NUM_BITS-wide subtractor, LSB first, one full-subtractor step per clock.
// Define SERIAL_SUB_OVF_EN to add a registered signed-overflow flag.
module serial_subtractor #(
  parameter int NUM_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_subtractor_if.slave   bus
);

  localparam int CNT_W = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state, state_next;
  logic [NUM_BITS-1:0] a_sr, b_sr, res_sr, res_next;
  logic                borrow;
  logic [CNT_W-1:0]    count;
  logic [NUM_BITS-1:0] diff_q;
  logic                borrow_q;
  logic                a_bit, b_bit, d_bit, borrow_next;
  logic                accept, last_bit;

  // Start is honoured only when no operation is in flight (IDLE or the DONE cycle).
  assign accept   = bus.start && ((state == IDLE) || (state == DONE));
  assign last_bit = (state == SHIFT) && (count == CNT_W'(NUM_BITS - 1));

  // Full-subtractor step on the current LSBs.
  assign a_bit       = a_sr[0];
  assign b_bit       = b_sr[0];
  assign d_bit       = a_bit ^ b_bit ^ borrow;
  assign borrow_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & borrow);
  assign res_next    = (res_sr >> 1) | {d_bit, {(NUM_BITS-1){1'b0}}};

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (bus.start) state_next = SHIFT;
      SHIFT:   if (last_bit)  state_next = DONE;
      DONE:    state_next = bus.start ? SHIFT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand shifters, borrow flop and bit counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      borrow <= 1'b0;
      count  <= '0;
    end else if (accept) begin
      a_sr   <= bus.minuend;
      b_sr   <= bus.subtrahend;
      res_sr <= '0;
      borrow <= 1'b0;
      count  <= '0;
    end else if (state == SHIFT) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res_sr <= res_next;
      borrow <= borrow_next;
      count  <= count + 1'b1;
    end
  end

  // Visible result only moves on the final shift edge, so it stays stable for
  // the whole of the next operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else if (last_bit) begin
      diff_q   <= res_next;
      borrow_q <= borrow_next;
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic ovf_q;

  // On the last step a_bit/b_bit are the operand MSBs and d_bit is the result MSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (last_bit) begin
      ovf_q <= (a_bit ^ b_bit) & (d_bit ^ a_bit);
    end
  end

  assign bus.overflow = ovf_q;
`endif

  assign bus.busy       = (state == SHIFT);
  assign bus.done       = (state == DONE);
  assign bus.difference = diff_q;
  assign bus.borrow_out = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed-vector bench for serial_subtractor; covers latency, underflow,
// back-to-back starts, ignored starts and asynchronous reset mid-operation.
module tb_serial_subtractor;

  localparam int NB = 8;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  serial_subtractor_if #(.NUM_BITS(NB)) sif ();

  serial_subtractor #(.NUM_BITS(NB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  // Present operands with start for exactly one rising edge.
  task automatic issue(input logic [NB-1:0] a, input logic [NB-1:0] b);
    sif.start      = 1'b1;
    sif.minuend    = a;
    sif.subtrahend = b;
    @(negedge clk);
    sif.start      = 1'b0;
  endtask

  // Count cycles until done, bounded; records whether busy stayed high meanwhile.
  task automatic wait_done(output int cyc, output bit busy_ok);
    cyc     = 0;
    busy_ok = 1'b1;
    while (sif.done !== 1'b1 && cyc < 40) begin
      if (sif.busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst            = 1'b1;
    sif.start      = 1'b0;
    sif.minuend    = '0;
    sif.subtrahend = '0;
    #12;
    n_vec++;
    if ({sif.busy, sif.done, sif.borrow_out, sif.difference} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got busy=%b done=%b br=%b diff=%h, want all 0",
               sif.busy, sif.done, sif.borrow_out, sif.difference);
    end
`ifdef SERIAL_SUB_OVF_EN
    n_vec++;
    if (sif.overflow !== 1'b0) begin
      n_err++;
      $display("FAIL reset_overflow: got %b, want 0", sif.overflow);
    end
`endif
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int cyc;
    bit bok;
    issue(8'd9, 8'd5);
    wait_done(cyc, bok);
    n_vec++;
    if (cyc !== 8 || !bok) begin
      n_err++;
      $display("FAIL basic_latency: busy cycles=%0d busy_ok=%b, want 8 and 1", cyc, bok);
    end
    n_vec++;
    if ({sif.done, sif.busy, sif.borrow_out, sif.difference} !== {3'b100, 8'd4}) begin
      n_err++;
      $display("FAIL basic_result: got done=%b busy=%b br=%b diff=%h, want 1 0 0 04",
               sif.done, sif.busy, sif.borrow_out, sif.difference);
    end
    @(negedge clk);
    n_vec++;
    if ({sif.done, sif.busy, sif.difference} !== {2'b00, 8'd4}) begin
      n_err++;
      $display("FAIL basic_pulse: got done=%b busy=%b diff=%h, want 0 0 04",
               sif.done, sif.busy, sif.difference);
    end
  endtask

  task automatic test_underflow;
    // {A, B, difference, borrow, overflow}
    logic [NB*3+1:0] vec [5];
    int cyc;
    bit bok;
    vec[0] = {8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
    vec[1] = {8'h05, 8'h09, 8'hFC, 1'b1, 1'b0};
    vec[2] = {8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0};
    vec[3] = {8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
    vec[4] = {8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      issue(vec[i][25:18], vec[i][17:10]);
      wait_done(cyc, bok);
      n_vec++;
      if (cyc !== 8 || {sif.borrow_out, sif.difference} !== {vec[i][1], vec[i][9:2]}) begin
        n_err++;
        $display("FAIL underflow_%0d: %h-%h got diff=%h br=%b cyc=%0d, want diff=%h br=%b cyc=8",
                 i, vec[i][25:18], vec[i][17:10], sif.difference, sif.borrow_out, cyc,
                 vec[i][9:2], vec[i][1]);
      end
`ifdef SERIAL_SUB_OVF_EN
      n_vec++;
      if (sif.overflow !== vec[i][0]) begin
        n_err++;
        $display("FAIL overflow_%0d: got %b, want %b", i, sif.overflow, vec[i][0]);
      end
`endif
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    bit bok;
    sif.start      = 1'b1;
    sif.minuend    = 8'hAA;
    sif.subtrahend = 8'hAA;
    @(negedge clk);
    wait_done(cyc, bok);
    n_vec++;
    if (cyc !== 8 || {sif.borrow_out, sif.difference} !== 9'h000) begin
      n_err++;
      $display("FAIL b2b_first: cyc=%0d diff=%h br=%b, want 8 00 0", cyc, sif.difference, sif.borrow_out);
    end
    @(negedge clk);
    sif.start = 1'b0;
    n_vec++;
    if (sif.busy !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_accept: busy=%b after DONE with start high, want 1", sif.busy);
    end
    wait_done(cyc, bok);
    n_vec++;
    if (cyc + 1 !== 9 || !bok || {sif.borrow_out, sif.difference} !== 9'h000) begin
      n_err++;
      $display("FAIL b2b_second: done spacing=%0d busy_ok=%b diff=%h br=%b, want 9 1 00 0",
               cyc + 1, bok, sif.difference, sif.borrow_out);
    end
    @(negedge clk);
  endtask

  task automatic test_busy_ignore;
    int cyc;
    bit bok;
    issue(8'd20, 8'd3);
    @(negedge clk);
    @(negedge clk);
    sif.start      = 1'b1;
    sif.minuend    = 8'd1;
    sif.subtrahend = 8'd2;
    @(negedge clk);
    sif.start = 1'b0;
    n_vec++;
    if (sif.busy !== 1'b1 || sif.difference !== 8'h00) begin
      n_err++;
      $display("FAIL ignore_midway: busy=%b diff=%h, want 1 and held 00", sif.busy, sif.difference);
    end
    wait_done(cyc, bok);
    n_vec++;
    if (cyc !== 5 || {sif.borrow_out, sif.difference} !== {1'b0, 8'd17}) begin
      n_err++;
      $display("FAIL ignore_result: cyc=%0d diff=%h br=%b, want 5 11 0", cyc, sif.difference, sif.borrow_out);
    end
    @(negedge clk);
    n_vec++;
    if ({sif.busy, sif.done} !== 2'b00) begin
      n_err++;
      $display("FAIL ignore_noqueue: busy=%b done=%b, want 0 0", sif.busy, sif.done);
    end
  endtask

  task automatic test_reset_mid;
    int cyc;
    bit bok;
    bit seen;
    issue(8'hF0, 8'h0F);
    repeat (3) @(negedge clk);
    n_vec++;
    if (sif.busy !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_busy: busy=%b before reset, want 1", sif.busy);
    end
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if ({sif.busy, sif.done, sif.borrow_out, sif.difference} !== '0) begin
      n_err++;
      $display("FAIL rstmid_async: busy=%b done=%b br=%b diff=%h, want all 0",
               sif.busy, sif.done, sif.borrow_out, sif.difference);
    end
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (sif.busy !== 1'b0 || sif.done !== 1'b0) seen = 1'b1;
    end
    n_vec++;
    if (seen !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_idle: activity after reset release, got 1, want 0");
    end
    issue(8'hF0, 8'h0F);
    wait_done(cyc, bok);
    n_vec++;
    if (cyc !== 8 || {sif.borrow_out, sif.difference} !== {1'b0, 8'hE1}) begin
      n_err++;
      $display("FAIL rstmid_recover: cyc=%0d diff=%h br=%b, want 8 E1 0", cyc, sif.difference, sif.borrow_out);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_underflow();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
